// File: rtl/axis_tx_arbiter_pkg.sv
// axis_tx_arbiter_pkg
//   Shared definitions for the TX frame arbiter: FSM state encodings and
//   status bit positions used to pack the MAC's per-frame status pulses.
//   Optional build macro used by this block: TX_ARB_STRICT_PRIO_EN.
package axis_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFwd  = 2'd1,
        StWait = 2'd2
    } arb_state_e;

    localparam int unsigned StatW         = 4;
    localparam int unsigned StatOk        = 0;
    localparam int unsigned StatGaveUp    = 1;
    localparam int unsigned StatLateCol   = 2;
    localparam int unsigned StatUnderflow = 3;

    function automatic logic [StatW-1:0] pack_status(input logic ok,
                                                     input logic gave_up,
                                                     input logic late_col,
                                                     input logic underflow);
        logic [StatW-1:0] s;
        s                = '0;
        s[StatOk]        = ok;
        s[StatGaveUp]    = gave_up;
        s[StatLateCol]   = late_col;
        s[StatUnderflow] = underflow;
        return s;
    endfunction

endpackage

// File: rtl/axis_tx_arbiter_rr_pick.sv
// axis_tx_arbiter_rr_pick
//   Combinational winner selection for the TX arbiter.
//   Default: round-robin, first valid port starting at i_last_grant+1 (mod PORTS).
//   With TX_ARB_STRICT_PRIO_EN defined: lowest-index valid port wins and
//   i_last_grant is ignored.
// Ports:
//   i_valid       per-port request vector
//   i_last_grant  index of the previously granted port
//   o_any         at least one request present
//   o_idx         index of the winning port (valid when o_any)
module axis_tx_arbiter_rr_pick
    import axis_tx_arbiter_pkg::*;
#(
    parameter int unsigned PORTS = 2,
    parameter int unsigned SEL_W = $clog2(PORTS)
) (
    input  logic [PORTS-1:0] i_valid,
    input  logic [SEL_W-1:0] i_last_grant,
    output logic             o_any,
    output logic [SEL_W-1:0] o_idx
);

    int unsigned      w_cand;
    logic [PORTS-1:0] w_rot;

`ifdef TX_ARB_STRICT_PRIO_EN
    logic w_unused_last_grant;
    assign w_unused_last_grant = ^i_last_grant;

    always_comb begin
        o_any  = 1'b0;
        o_idx  = '0;
        w_cand = 0;
        w_rot  = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            w_cand = i;
            w_rot  = i_valid >> w_cand;
            if (!o_any && w_rot[0]) begin
                o_any = 1'b1;
                o_idx = SEL_W'(w_cand);
            end
        end
    end
`else
    always_comb begin
        o_any  = 1'b0;
        o_idx  = '0;
        w_cand = 0;
        w_rot  = '0;
        // Scan PORTS candidates beginning just after the previous winner.
        for (int unsigned off = 1; off <= PORTS; off++) begin
            w_cand = (32'(i_last_grant) + off) % PORTS;
            w_rot  = i_valid >> w_cand;
            if (!o_any && w_rot[0]) begin
                o_any = 1'b1;
                o_idx = SEL_W'(w_cand);
            end
        end
    end
`endif

endmodule

// File: rtl/axis_tx_arbiter.sv
// axis_tx_arbiter
//   Frame-granular arbiter sharing one TX MAC between PORTS AXI-stream byte
//   sources. A grant is locked for a whole frame; beats pass combinationally.
//   The MAC's first status pulse of a frame is captured and returned as a
//   one-cycle pulse to the port that owned the frame.
//   Build option: define TX_ARB_STRICT_PRIO_EN for fixed priority (port 0
//   highest) instead of round-robin.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_axis_*              per-port source streams (port i data at [8i+7:8i])
//   m_axis_*              stream towards the MAC
//   mac_*                 MAC per-frame status pulses
//   status_valid          one-hot pulse to the owning port on completion
//   status_*              status bits, qualified by status_valid
//   busy                  high while a frame is owned (not idle)
module axis_tx_arbiter
    import axis_tx_arbiter_pkg::*;
#(
    parameter  int unsigned PORTS = 2,
    localparam int unsigned SEL_W = $clog2(PORTS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PORTS*8-1:0] s_axis_data,
    input  logic [PORTS-1:0]   s_axis_valid,
    output logic [PORTS-1:0]   s_axis_ready,
    input  logic [PORTS-1:0]   s_axis_last,
    input  logic [PORTS-1:0]   s_axis_err,
    output logic [7:0]         m_axis_data,
    output logic               m_axis_valid,
    input  logic               m_axis_ready,
    output logic               m_axis_last,
    output logic               m_axis_err,
    input  logic               mac_transmit_ok,
    input  logic               mac_gave_up,
    input  logic               mac_late_collision,
    input  logic               mac_underflow,
    output logic [PORTS-1:0]   status_valid,
    output logic               status_ok,
    output logic               status_gave_up,
    output logic               status_late_collision,
    output logic               status_underflow,
    output logic               busy
);

    arb_state_e       r_state, w_state_nxt;
    logic [SEL_W-1:0] r_sel, w_sel_nxt;
    logic [SEL_W-1:0] r_last_grant, w_last_grant_nxt;
    logic             r_stat_seen, w_stat_seen_nxt;
    logic [StatW-1:0] r_stat_reg, w_stat_reg_nxt;
    logic [PORTS-1:0] r_status_valid, w_status_valid_nxt;
    logic [StatW-1:0] r_status_bits, w_status_bits_nxt;

    logic             w_pick_any;
    logic [SEL_W-1:0] w_pick_idx;
    logic [StatW-1:0] w_pulse;
    logic             w_any_pulse;
    logic             w_fwd;
    logic [PORTS-1:0] w_sel_onehot;
    logic             w_last_hs;
    logic             w_done;

    axis_tx_arbiter_rr_pick #(
        .PORTS (PORTS),
        .SEL_W (SEL_W)
    ) u_pick (
        .i_valid      (s_axis_valid),
        .i_last_grant (r_last_grant),
        .o_any        (w_pick_any),
        .o_idx        (w_pick_idx)
    );

    assign w_pulse      = pack_status(mac_transmit_ok, mac_gave_up, mac_late_collision,
                                      mac_underflow);
    assign w_any_pulse  = |w_pulse;
    assign w_fwd        = (r_state == StFwd);
    assign w_sel_onehot = PORTS'(1) << r_sel;

    // Datapath is a pure mux on the locked selection; nothing passes outside FWD.
    assign m_axis_valid = w_fwd & |(s_axis_valid & w_sel_onehot);
    assign m_axis_last  = w_fwd & |(s_axis_last & w_sel_onehot);
    assign m_axis_err   = w_fwd & |(s_axis_err & w_sel_onehot);
    assign m_axis_data  = w_fwd ? s_axis_data[8*r_sel +: 8] : 8'h00;
    assign s_axis_ready = (w_fwd && m_axis_ready) ? w_sel_onehot : '0;
    assign w_last_hs    = m_axis_valid & m_axis_ready & m_axis_last;

    assign busy                  = (r_state != StIdle);
    assign status_valid          = r_status_valid;
    assign status_ok             = r_status_bits[StatOk];
    assign status_gave_up        = r_status_bits[StatGaveUp];
    assign status_late_collision = r_status_bits[StatLateCol];
    assign status_underflow      = r_status_bits[StatUnderflow];

    always_comb begin
        w_state_nxt        = r_state;
        w_sel_nxt          = r_sel;
        w_last_grant_nxt   = r_last_grant;
        w_stat_seen_nxt    = r_stat_seen;
        w_stat_reg_nxt     = r_stat_reg;
        w_status_valid_nxt = '0;
        w_status_bits_nxt  = '0;
        w_done             = 1'b0;

        // Only the first status pulse of a frame is kept.
        if (r_state != StIdle && !r_stat_seen && w_any_pulse) begin
            w_stat_seen_nxt = 1'b1;
            w_stat_reg_nxt  = w_pulse;
        end

        case (r_state)
            StIdle: begin
                if (w_pick_any) begin
                    w_sel_nxt        = w_pick_idx;
                    w_last_grant_nxt = w_pick_idx;
                    w_state_nxt      = StFwd;
                end
            end
            StFwd: begin
                // Early status does not end the frame: the MAC drains the source.
                if (w_last_hs) begin
                    if (r_stat_seen || w_any_pulse) begin
                        w_done = 1'b1;
                    end else begin
                        w_state_nxt = StWait;
                    end
                end
            end
            StWait: begin
                if (w_any_pulse) begin
                    w_done = 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase

        if (w_done) begin
            w_state_nxt        = StIdle;
            w_status_valid_nxt = w_sel_onehot;
            w_status_bits_nxt  = r_stat_seen ? r_stat_reg : w_pulse;
            w_stat_seen_nxt    = 1'b0;
            w_stat_reg_nxt     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= StIdle;
            r_sel          <= '0;
            r_last_grant   <= SEL_W'(PORTS - 1);
            r_stat_seen    <= 1'b0;
            r_stat_reg     <= '0;
            r_status_valid <= '0;
            r_status_bits  <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_sel          <= w_sel_nxt;
            r_last_grant   <= w_last_grant_nxt;
            r_stat_seen    <= w_stat_seen_nxt;
            r_stat_reg     <= w_stat_reg_nxt;
            r_status_valid <= w_status_valid_nxt;
            r_status_bits  <= w_status_bits_nxt;
        end
    end

endmodule

// File: tb/tb_axis_tx_arbiter.sv
// Scoreboard bench for axis_tx_arbiter with three ports. Stimulus pushes
// expected beats and status records into queues; a monitor pops and compares
// whenever the DUT hands a beat to the MAC or pulses status_valid.
module tb_axis_tx_arbiter;

    localparam int unsigned NP = 3;

    typedef struct packed {
        logic       err;
        logic       last;
        logic [7:0] data;
    } beat_t;

    typedef struct packed {
        logic [1:0] port;
        logic [3:0] bits;   // {underflow, late_col, gave_up, ok}
        logic [7:0] gap;    // cycles from last handshake to status; 0 = any
    } stat_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NP*8-1:0] s_axis_data;
    logic [NP-1:0]   s_axis_valid;
    logic [NP-1:0]   s_axis_ready;
    logic [NP-1:0]   s_axis_last;
    logic [NP-1:0]   s_axis_err;
    logic [7:0]      m_axis_data;
    logic            m_axis_valid;
    logic            m_axis_ready;
    logic            m_axis_last;
    logic            m_axis_err;
    logic            mac_transmit_ok;
    logic            mac_gave_up;
    logic            mac_late_collision;
    logic            mac_underflow;
    logic [NP-1:0]   status_valid;
    logic            status_ok;
    logic            status_gave_up;
    logic            status_late_collision;
    logic            status_underflow;
    logic            busy;

    logic [3:0] mac_st = 4'b0;
    assign mac_transmit_ok    = mac_st[0];
    assign mac_gave_up        = mac_st[1];
    assign mac_late_collision = mac_st[2];
    assign mac_underflow      = mac_st[3];

    axis_tx_arbiter #(
        .PORTS (NP)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .s_axis_data           (s_axis_data),
        .s_axis_valid          (s_axis_valid),
        .s_axis_ready          (s_axis_ready),
        .s_axis_last           (s_axis_last),
        .s_axis_err            (s_axis_err),
        .m_axis_data           (m_axis_data),
        .m_axis_valid          (m_axis_valid),
        .m_axis_ready          (m_axis_ready),
        .m_axis_last           (m_axis_last),
        .m_axis_err            (m_axis_err),
        .mac_transmit_ok       (mac_transmit_ok),
        .mac_gave_up           (mac_gave_up),
        .mac_late_collision    (mac_late_collision),
        .mac_underflow         (mac_underflow),
        .status_valid          (status_valid),
        .status_ok             (status_ok),
        .status_gave_up        (status_gave_up),
        .status_late_collision (status_late_collision),
        .status_underflow      (status_underflow),
        .busy                  (busy)
    );

    always #5 clk = ~clk;

    beat_t src_q [NP][$];
    beat_t exp_beat_q [$];
    stat_t exp_st_q [$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int mon_frame_beats = 0;
    int mon_frames_done = 0;
    int last_hs_cyc     = 0;
    int leak_cnt        = 0;

    // MAC model configuration
    bit         auto_en    = 1'b0;
    int         auto_delay = 20;
    logic [3:0] auto_bits  = 4'b0001;
    int         early_at   = -1;
    logic [3:0] early_bits = 4'b0;
    bit         early_done = 1'b0;
    int         bo_at      = -1;
    int         bo_len     = 0;
    bit         bo_done    = 1'b0;
    int         bo_rem     = 0;
    bit         same_en    = 1'b0;
    logic [3:0] same_bits  = 4'b0;
    logic [3:0] force_st   = 4'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic beat_t mk_beat(input logic [7:0] base, input int i, input int len,
                                      input int err_at);
        beat_t b;
        b.data = base + 8'(i);
        b.last = (i == len - 1);
        b.err  = (i == err_at);
        return b;
    endfunction

    task automatic add_frame(input int port, input int len, input logic [7:0] base,
                             input int err_at);
        for (int i = 0; i < len; i++) src_q[port].push_back(mk_beat(base, i, len, err_at));
    endtask

    task automatic exp_frame(input int len, input logic [7:0] base, input int err_at);
        for (int i = 0; i < len; i++) exp_beat_q.push_back(mk_beat(base, i, len, err_at));
    endtask

    task automatic exp_status(input int port, input logic [3:0] bits, input int gap);
        stat_t s;
        s.port = 2'(port);
        s.bits = bits;
        s.gap  = 8'(gap);
        exp_st_q.push_back(s);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int k;
        k = 0;
        while ((exp_beat_q.size() != 0 || exp_st_q.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        #1;
        chk(name, exp_beat_q.size() + exp_st_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [21:0] all_outs();
        return {m_axis_valid, m_axis_data, m_axis_last, m_axis_err, s_axis_ready,
                status_valid, status_ok, status_gave_up, status_late_collision,
                status_underflow, busy};
    endfunction

    // Source driver: present queue heads, pop on handshake.
    initial begin
        logic [NP-1:0] hs;
        s_axis_valid = '0;
        s_axis_data  = '0;
        s_axis_last  = '0;
        s_axis_err   = '0;
        forever begin
            @(negedge clk);
            hs = s_axis_valid & s_axis_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NP; i++) begin
                if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    s_axis_valid[i]       = 1'b1;
                    s_axis_data[i*8 +: 8] = src_q[i][0].data;
                    s_axis_last[i]        = src_q[i][0].last;
                    s_axis_err[i]         = src_q[i][0].err;
                end else begin
                    s_axis_valid[i]       = 1'b0;
                    s_axis_data[i*8 +: 8] = 8'h00;
                    s_axis_last[i]        = 1'b0;
                    s_axis_err[i]         = 1'b0;
                end
            end
        end
    end

    // MAC model: ready/backoff and status pulse generation.
    initial begin
        int mac_cd;
        int seen;
        mac_cd       = 0;
        seen         = 0;
        m_axis_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            mac_st   = force_st;
            force_st = 4'b0;
            if (bo_rem > 0) begin
                bo_rem--;
                if (bo_rem == 0) m_axis_ready = 1'b1;
            end else if (bo_at >= 0 && !bo_done && busy && mon_frame_beats == bo_at) begin
                m_axis_ready = 1'b0;
                bo_rem       = bo_len;
                bo_done      = 1'b1;
            end
            if (mon_frames_done != seen) begin
                seen = mon_frames_done;
                if (auto_en) mac_cd = auto_delay;
            end
            if (mac_cd > 0) begin
                mac_cd--;
                if (mac_cd == 0) mac_st |= auto_bits;
            end
            if (early_at >= 0 && !early_done && busy && mon_frame_beats == early_at) begin
                mac_st |= early_bits;
                early_done = 1'b1;
            end
            if (same_en && m_axis_valid && m_axis_last && m_axis_ready) mac_st |= same_bits;
        end
    end

    // Monitor / scoreboard.
    initial begin
        beat_t         eb;
        stat_t         es;
        logic [NP-1:0] onehot;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (m_axis_valid && m_axis_ready) begin
                    if (exp_beat_q.size() == 0) begin
                        chk("unexpected_beat", m_axis_valid & m_axis_ready, 0);
                    end else begin
                        eb = exp_beat_q.pop_front();
                        chk("beat", {m_axis_err, m_axis_last, m_axis_data}, eb);
                    end
                    mon_frame_beats++;
                    if (m_axis_last) begin
                        mon_frame_beats = 0;
                        mon_frames_done++;
                        last_hs_cyc = cyc;
                    end
                end
                if (!m_axis_ready && s_axis_ready != '0) leak_cnt++;
                if (status_valid != '0) begin
                    if (exp_st_q.size() == 0) begin
                        chk("unexpected_status", status_valid, 0);
                    end else begin
                        es     = exp_st_q.pop_front();
                        onehot = NP'(1) << es.port;
                        chk("status_port", status_valid, onehot);
                        chk("status_bits", {status_underflow, status_late_collision,
                                            status_gave_up, status_ok}, es.bits);
                        if (es.gap != 0) chk("status_gap", cyc - last_hs_cyc, es.gap);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks", n_checks);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("reset_outputs", all_outs(), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // 1: ports 0 and 1 two frames each, round-robin, ok status 20 cycles later
        auto_en = 1'b1; auto_delay = 20; auto_bits = 4'b0001;
        add_frame(0, 60, 8'h00, -1);
        add_frame(0, 60, 8'h40, -1);
        add_frame(1, 60, 8'h80, 7);
        add_frame(1, 60, 8'hC0, -1);
`ifdef TX_ARB_STRICT_PRIO_EN
        exp_frame(60, 8'h00, -1); exp_status(0, 4'b0001, 0);
        exp_frame(60, 8'h40, -1); exp_status(0, 4'b0001, 0);
        exp_frame(60, 8'h80, 7);  exp_status(1, 4'b0001, 0);
        exp_frame(60, 8'hC0, -1); exp_status(1, 4'b0001, 0);
`else
        exp_frame(60, 8'h00, -1); exp_status(0, 4'b0001, 0);
        exp_frame(60, 8'h80, 7);  exp_status(1, 4'b0001, 0);
        exp_frame(60, 8'h40, -1); exp_status(0, 4'b0001, 0);
        exp_frame(60, 8'hC0, -1); exp_status(1, 4'b0001, 0);
`endif
        wait_drain(2000, "t1_drain");

        // 2: underflow at byte 10 of 100; frame still fully forwarded
        auto_en = 1'b0;
        early_at = 10; early_bits = 4'b1000; early_done = 1'b0;
        add_frame(0, 100, 8'h10, -1);
        exp_frame(100, 8'h10, -1);
        exp_status(0, 4'b1000, 1);
        wait_drain(400, "t2_drain");
        early_at = -1;

        // 3: late collision in the last-handshake cycle; no WAIT
        same_en = 1'b1; same_bits = 4'b0100;
        add_frame(1, 8, 8'h20, -1);
        exp_frame(8, 8'h20, -1);
        exp_status(1, 4'b0100, 1);
        wait_drain(100, "t3_drain");
        same_en = 1'b0;
        chk("t3_idle_after", busy, 0);

        // 4: 500-cycle backoff mid-frame on port 0 while port 1 waits
        auto_en = 1'b1; auto_delay = 5; auto_bits = 4'b0001;
        bo_at = 20; bo_len = 500; bo_done = 1'b0;
        add_frame(0, 60, 8'h30, -1);
        add_frame(1, 10, 8'h90, -1);
        exp_frame(60, 8'h30, -1); exp_status(0, 4'b0001, 0);
        exp_frame(10, 8'h90, -1); exp_status(1, 4'b0001, 0);
        wait_drain(1500, "t4_drain");
        chk("t4_ready_leak", leak_cnt, 0);
        bo_at = -1;

        // 5: reset at byte 30 of a port-1 frame
        auto_en = 1'b0;
        add_frame(1, 60, 8'h50, -1);
        exp_frame(60, 8'h50, -1);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            #1;
            if (mon_frame_beats == 30) break;
        end
        chk("t5_reached_byte30", mon_frame_beats, 30);
        rst_n = 1'b0;
        #1;
        chk("t5_reset_outputs", all_outs(), 0);
        for (int i = 0; i < NP; i++) src_q[i].delete();
        exp_beat_q.delete();
        exp_st_q.delete();
        mon_frame_beats = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        force_st = 4'b0010;  // stale MAC status while idle
        repeat (6) @(negedge clk);
        chk("t5_idle_after_stale", busy, 0);
        auto_en = 1'b1; auto_delay = 3; auto_bits = 4'b0001;
        add_frame(2, 10, 8'hA0, -1);
        add_frame(0, 10, 8'hB0, -1);
        exp_frame(10, 8'hB0, -1); exp_status(0, 4'b0001, 0);
        exp_frame(10, 8'hA0, -1); exp_status(2, 4'b0001, 0);
        wait_drain(200, "t5_drain");
        chk("final_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_tx_arbiter.md
Name: axis_tx_arbiter

Overview:
- Frame-granular arbiter sharing one half-duplex 100M TX MAC between PORTS AXI-stream frame sources.
- Locks a grant for one whole frame and passes its beats to the MAC with zero latency.
- Collects the MAC's single per-frame transmit status and routes it back to the port that owned the frame.
- Sits between per-queue frame sources and the MAC's axis input/status outputs.

Parameters:
- PORTS, 2, number of requesters; legal range 2..8.
- SEL_W, $clog2(PORTS), derived; width of the grant index.

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous, active-low
- s_axis_data  in  PORTS*8  per-port byte; port i at [8i+7:8i]
- s_axis_valid  in  PORTS  per-port valid
- s_axis_ready  out  PORTS  per-port ready
- s_axis_last  in  PORTS  per-port end of frame
- s_axis_err  in  PORTS  per-port error flag for the beat
- m_axis_data  out  8  to MAC axis_data
- m_axis_valid  out  1  to MAC axis_valid
- m_axis_ready  in  1  from MAC axis_ready
- m_axis_last  out  1  to MAC axis_last
- m_axis_err  out  1  to MAC axis_err
- mac_transmit_ok, mac_gave_up, mac_late_collision, mac_underflow  in  1 each  MAC status pulses
- status_valid  out  PORTS  one-hot, one-cycle pulse to the owning port
- status_ok, status_gave_up, status_late_collision, status_underflow  out  1 each  qualified by status_valid
- busy  out  1  high while not IDLE

Behaviour:
- States: IDLE, FWD, WAIT.
- IDLE, no valid: stay in IDLE. IDLE, any s_axis_valid: pick winner (round-robin, first valid starting at last_grant+1 mod PORTS), register sel and last_grant, go to FWD. Arbitration latency is 1 cycle. No beat passes in IDLE.
- FWD: m_axis_* = s_axis_*[sel], combinational. s_axis_ready[i] = (i==sel) && m_axis_ready. All other readies are 0.
- FWD: a valid frame source can change mid-frame only at a handshake with last. Grant never changes before the last handshake, even if valid drops (underflow is the MAC's problem).
- Status capture: any MAC status pulse while in FWD or WAIT is latched once into stat_seen plus a 4-bit stat_reg. Later pulses in the same frame are ignored. Pulses in IDLE are ignored.
- FWD, last handshake (valid && ready && last):
  - stat_seen already set, or a status pulse in the same cycle: complete, go to IDLE.
  - Otherwise: go to WAIT.
- Early status during FWD (MAC underflow, late collision or drain) does not end FWD. The arbiter keeps forwarding until the last handshake, because the MAC drains the source.
- WAIT: on any status pulse, complete and go to IDLE. m_axis_valid=0 and all s_axis_ready=0.
- Complete: the next cycle drives status_valid[sel]=1 for exactly one cycle, with stat_reg bits (or same-cycle pulse bits) on the status_* outputs. Clear stat_seen.
- Back-to-back: a new grant can occur in the IDLE cycle right after completion. That gives a minimum 2-cycle gap, which is negligible against the MAC IPG.
- Reset (async, any state): state=IDLE, sel=0, last_grant=PORTS-1 so port 0 wins first, stat_seen=0, stat_reg=0. All outputs 0: status_valid, status_*, busy, m_axis_valid, s_axis_ready.
- Reset mid-frame abandons the frame. No status is emitted.

Optional Feature:
- Macro TX_ARB_STRICT_PRIO_EN.
- Defined: the IDLE pick is the lowest-index valid port (port 0 highest priority); last_grant is unused.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Decomposition:
- Shared header eth_mac_defs.vh holds:
  - state encodings IDLE=0, FWD=1, WAIT=2;
  - status bit indices OK=0, GAVE_UP=1, LATE_COL=2, UNDERFLOW=3.
- One combinational sub-module rr_pick: input valid vector + last_grant; outputs any flag + index. Strict-priority variant is selected inside it under the macro.

Test Plan:
- Ports 0 and 1 both valid with 60-byte frames; MAC ready, transmit_ok 20 cycles after each last -> frames sent 0,1,0,1; status_valid=01 then 10, status_ok=1.
- Status before last: MAC pulses mac_underflow at byte 10 of 100, then keeps ready -> all 100 bytes forwarded; status_valid pulses once after the last handshake with status_underflow=1.
- Last handshake and mac_late_collision in the same cycle -> no WAIT cycle; status_late_collision pulse on the next cycle; IDLE after.
- m_axis_ready held low 500 cycles mid-frame (backoff) while port 1 is valid -> sel stays 0, s_axis_ready[1]=0 throughout, no beat loss or duplication.
- rst_n pulsed low mid-frame at byte 30 -> all outputs 0 immediately; after release port 0 is granted first, and the stale MAC status is ignored in IDLE.
- TX_ARB_STRICT_PRIO_EN build, ports 0 and 2 continuously valid -> port 0 granted every frame; port 2 only when port 0 is idle.
